// File: rtl/init_seq_monitor_pkg.sv
// ---------------------------------------------------------------------------
// init_seq_pkg
//   Shared types for the init/calibration supervisor.
//   state_t : supervisor FSM encoding (also driven onto the STATE output)
//   STATE_W : width of the STATE output
// ---------------------------------------------------------------------------
package init_seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        WAIT    = 3'd0,
        RELEASE = 3'd1,
        RUN     = 3'd2,
        TMO     = 3'd3,
        FAULT   = 3'd4
    } state_t;

endpackage

// File: rtl/init_seq_monitor_if.sv
// ---------------------------------------------------------------------------
// init_seq_monitor_if
//   Status/reset bundle of the init supervisor.
//   FLAGS_IN   : asynchronous done/status flags, active high
//   CLR_FAULT  : synchronous pulse clearing the sticky status
//   RST_N_OUT  : active-low domain resets, bit 0 released first
//   ALL_DONE   : high while the supervisor is in RUN
//   TIMEOUT    : sticky wait-timeout flag
//   FAULT      : sticky loss-of-done flag
//   LOST_FLAGS : sticky record of required flags that dropped
//   STATE      : current FSM state encoding
//   master modport: the side driving flags (bench / system)
//   slave modport : the supervisor itself
// ---------------------------------------------------------------------------
interface init_seq_monitor_if #(
    parameter int NUM_FLAGS = 16,
    parameter int NUM_RST   = 4
) ();

    logic [NUM_FLAGS-1:0]              FLAGS_IN;
    logic                              CLR_FAULT;
    logic [NUM_RST-1:0]                RST_N_OUT;
    logic                              ALL_DONE;
    logic                              TIMEOUT;
    logic                              FAULT;
    logic [NUM_FLAGS-1:0]              LOST_FLAGS;
    logic [init_seq_pkg::STATE_W-1:0]  STATE;

    modport master (
        output FLAGS_IN, CLR_FAULT,
        input  RST_N_OUT, ALL_DONE, TIMEOUT, FAULT, LOST_FLAGS, STATE
    );

    modport slave (
        input  FLAGS_IN, CLR_FAULT,
        output RST_N_OUT, ALL_DONE, TIMEOUT, FAULT, LOST_FLAGS, STATE
    );

endinterface

// File: rtl/init_seq_monitor_flag_filter.sv
// ---------------------------------------------------------------------------
// init_flag_filter
//   One status flag: SYNC_STAGES-deep synchroniser followed by a saturating
//   run-length counter. stable is high once the synchronised flag has been
//   1 for STABLE_CYCLES consecutive cycles; any 0 restarts the count.
//   clk     : fabric clock
//   rst_n   : asynchronous active-low reset
//   flag_in : asynchronous flag
//   stable  : filtered flag
// ---------------------------------------------------------------------------
module init_flag_filter #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flag_in,
    output logic stable
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q,  cnt_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], flag_in};
        cnt_d  = '0;
        if (sync_q[SYNC_STAGES-1]) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
        end
    end

    assign stable = (cnt_q == CNT_MAX);

endmodule

// File: rtl/init_seq_monitor.sv
// ---------------------------------------------------------------------------
// init_seq_monitor
//   Fabric bring-up supervisor. Filters NUM_FLAGS done/status flags, waits
//   until every required flag is stable, then releases NUM_RST reset domains
//   one by one, RST_GAP cycles apart. Watches for a wait timeout and for any
//   required flag dropping afterwards, in which case all resets re-assert.
//   CLK    : fabric clock
//   RESETN : asynchronous active-low reset
//   bus    : flags in, CLR_FAULT in, resets/status/state out (slave modport)
// ---------------------------------------------------------------------------
module init_seq_monitor
    import init_seq_pkg::*;
#(
    parameter int                   NUM_FLAGS      = 16,
    parameter logic [NUM_FLAGS-1:0] REQ_MASK       = {NUM_FLAGS{1'b1}},
    parameter int                   SYNC_STAGES    = 2,
    parameter int                   STABLE_CYCLES  = 16,
    parameter int                   TIMEOUT_CYCLES = 1000000,
    parameter int                   NUM_RST        = 4,
    parameter int                   RST_GAP        = 8,
    parameter int                   AUTO_RETRY     = 1
) (
    input logic               CLK,
    input logic               RESETN,
    init_seq_monitor_if.slave bus
);

    // With the timeout disabled the counter is unused; keep it one bit wide.
    localparam int TCNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int GCNT_W = $clog2(RST_GAP + 1);
    localparam int IDX_W  = $clog2(NUM_RST + 1);

    localparam logic [TCNT_W-1:0] TCNT_LAST =
        (TIMEOUT_CYCLES > 0) ? TCNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [GCNT_W-1:0] GCNT_LAST = GCNT_W'(RST_GAP - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_RST - 1);

    logic [NUM_FLAGS-1:0] stable;
    logic [NUM_FLAGS-1:0] loss_vec;
    logic                 all_ok;

    state_t               state_q,   state_d;
    logic [TCNT_W-1:0]    tcnt_q,    tcnt_d;
    logic [GCNT_W-1:0]    gcnt_q,    gcnt_d;
    logic [IDX_W-1:0]     idx_q,     idx_d;
    logic [NUM_RST-1:0]   rst_n_q,   rst_n_d;
    logic                 timeout_q, timeout_d;
    logic                 fault_q,   fault_d;
    logic [NUM_FLAGS-1:0] lost_q,    lost_d;

    logic                 timeout_set;
    logic                 fault_set;
    logic [NUM_FLAGS-1:0] lost_set;

    for (genvar i = 0; i < NUM_FLAGS; i++) begin : g_flag
        init_flag_filter #(
            .SYNC_STAGES   (SYNC_STAGES),
            .STABLE_CYCLES (STABLE_CYCLES)
        ) u_filter (
            .clk     (CLK),
            .rst_n   (RESETN),
            .flag_in (bus.FLAGS_IN[i]),
            .stable  (stable[i])
        );
    end

    // Unrequired flags are forced "good" so they never gate or fault.
    assign loss_vec = REQ_MASK & ~stable;
    assign all_ok   = &(stable | ~REQ_MASK);

    always_comb begin
        state_d     = state_q;
        tcnt_d      = '0;           // only WAIT counts, so re-entry starts at 0
        gcnt_d      = gcnt_q;
        idx_d       = idx_q;
        rst_n_d     = rst_n_q;
        timeout_set = 1'b0;
        fault_set   = 1'b0;
        lost_set    = '0;

        unique case (state_q)
            WAIT: begin
                tcnt_d = (&tcnt_q) ? tcnt_q : tcnt_q + 1'b1;
                // all_ok is tested first so it wins over a same-cycle timeout.
                if (all_ok) begin
                    state_d = RELEASE;
                    gcnt_d  = '0;
                    idx_d   = '0;
                end else if (TIMEOUT_CYCLES != 0 && tcnt_q == TCNT_LAST) begin
                    state_d     = TMO;
                    timeout_set = 1'b1;
                end
            end
            RELEASE: begin
                if (|loss_vec) begin
                    state_d   = FAULT;
                    rst_n_d   = '0;
                    fault_set = 1'b1;
                    lost_set  = loss_vec;
                end else if (gcnt_q == GCNT_LAST) begin
                    gcnt_d = '0;
                    idx_d  = idx_q + 1'b1;
                    for (int k = 0; k < NUM_RST; k++) begin
                        if (idx_q == IDX_W'(k)) begin
                            rst_n_d[k] = 1'b1;
                        end
                    end
                    if (idx_q == IDX_LAST) begin
                        state_d = RUN;
                    end
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                end
            end
            RUN: begin
                if (|loss_vec) begin
                    state_d   = FAULT;
                    rst_n_d   = '0;
                    fault_set = 1'b1;
                    lost_set  = loss_vec;
                end
            end
            TMO: begin
                if (all_ok) begin
                    state_d = RELEASE;
                    gcnt_d  = '0;
                    idx_d   = '0;
                end
            end
            FAULT: begin
                if (AUTO_RETRY != 0 || bus.CLR_FAULT) begin
                    state_d = WAIT;
                end
            end
            default: begin
                state_d = WAIT;
                rst_n_d = '0;
            end
        endcase

        // Sticky status: a new set in the same cycle as CLR_FAULT wins.
        timeout_d = timeout_set | (timeout_q & ~bus.CLR_FAULT);
        fault_d   = fault_set   | (fault_q   & ~bus.CLR_FAULT);
        lost_d    = lost_set    | (bus.CLR_FAULT ? '0 : lost_q);
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q   <= WAIT;
            tcnt_q    <= '0;
            gcnt_q    <= '0;
            idx_q     <= '0;
            rst_n_q   <= '0;
            timeout_q <= 1'b0;
            fault_q   <= 1'b0;
            lost_q    <= '0;
        end else begin
            state_q   <= state_d;
            tcnt_q    <= tcnt_d;
            gcnt_q    <= gcnt_d;
            idx_q     <= idx_d;
            rst_n_q   <= rst_n_d;
            timeout_q <= timeout_d;
            fault_q   <= fault_d;
            lost_q    <= lost_d;
        end
    end

    assign bus.RST_N_OUT  = rst_n_q;
    assign bus.ALL_DONE   = (state_q == RUN);
    assign bus.TIMEOUT    = timeout_q;
    assign bus.FAULT      = fault_q;
    assign bus.LOST_FLAGS = lost_q;
    assign bus.STATE      = state_q;

endmodule

// File: tb/tb_init_seq_monitor.sv
// ---------------------------------------------------------------------------
// tb_init_seq_monitor
//   Three supervisor instances sharing one clock:
//     inst 0 : REQ_MASK=4'hF, AUTO_RETRY=1
//     inst 1 : REQ_MASK=4'hF, AUTO_RETRY=0
//     inst 2 : REQ_MASK=4'h7, AUTO_RETRY=1
//   A reference model tracks each instance from flag history and elapsed
//   cycle counts; DUT outputs are compared against it every cycle.
// ---------------------------------------------------------------------------
module tb_init_seq_monitor;

    localparam int NF    = 4;
    localparam int NR    = 3;
    localparam int SYNC  = 2;
    localparam int STAB  = 4;
    localparam int GAP   = 2;
    localparam int TCYC  = 50;
    localparam int HIST  = SYNC + STAB;

    logic       clk = 1'b0;
    logic [3:0] flags [3];
    logic       clr   [3];
    logic       rstn  [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    init_seq_monitor_if #(.NUM_FLAGS(NF), .NUM_RST(NR)) ifa ();
    init_seq_monitor_if #(.NUM_FLAGS(NF), .NUM_RST(NR)) ifb ();
    init_seq_monitor_if #(.NUM_FLAGS(NF), .NUM_RST(NR)) ifc ();

    assign ifa.FLAGS_IN = flags[0];
    assign ifa.CLR_FAULT = clr[0];
    assign ifb.FLAGS_IN = flags[1];
    assign ifb.CLR_FAULT = clr[1];
    assign ifc.FLAGS_IN = flags[2];
    assign ifc.CLR_FAULT = clr[2];

    init_seq_monitor #(.NUM_FLAGS(NF), .REQ_MASK(4'hF), .SYNC_STAGES(SYNC), .STABLE_CYCLES(STAB),
        .TIMEOUT_CYCLES(TCYC), .NUM_RST(NR), .RST_GAP(GAP), .AUTO_RETRY(1))
        dut_a (.CLK(clk), .RESETN(rstn[0]), .bus(ifa));
    init_seq_monitor #(.NUM_FLAGS(NF), .REQ_MASK(4'hF), .SYNC_STAGES(SYNC), .STABLE_CYCLES(STAB),
        .TIMEOUT_CYCLES(TCYC), .NUM_RST(NR), .RST_GAP(GAP), .AUTO_RETRY(0))
        dut_b (.CLK(clk), .RESETN(rstn[1]), .bus(ifb));
    init_seq_monitor #(.NUM_FLAGS(NF), .REQ_MASK(4'h7), .SYNC_STAGES(SYNC), .STABLE_CYCLES(STAB),
        .TIMEOUT_CYCLES(TCYC), .NUM_RST(NR), .RST_GAP(GAP), .AUTO_RETRY(1))
        dut_c (.CLK(clk), .RESETN(rstn[2]), .bus(ifc));

    // ---------------- reference model ----------------
    // mode: 0 WAIT, 1 RELEASE, 2 RUN, 3 TMO, 4 FAULT
    logic [3:0] mask  [3] = '{4'hF, 4'hF, 4'h7};
    bit         retry [3] = '{1'b1, 1'b0, 1'b1};
    logic [3:0] hist  [3][HIST];   // hist[i][0] = flags sampled one edge ago
    int         mode  [3];
    int         wcnt  [3];         // edges spent in WAIT since entering it
    int         rel_t [3];         // edges since entering RELEASE
    bit         m_tmo [3];
    bit         m_flt [3];
    logic [3:0] m_lost[3];

    logic [3:0] mdl_stab, mdl_loss, mdl_new;
    bit         mdl_st, mdl_sf;

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rstn[i]) begin
                for (int k = 0; k < HIST; k++) hist[i][k] = 4'h0;
                mode[i] = 0; wcnt[i] = 0; rel_t[i] = 0;
                m_tmo[i] = 0; m_flt[i] = 0; m_lost[i] = 4'h0;
            end else begin
                // Stable = the STAB samples that have cleared the synchroniser were all 1.
                mdl_stab = 4'hF;
                for (int k = SYNC; k < HIST; k++) mdl_stab &= hist[i][k];
                mdl_loss = mask[i] & ~mdl_stab;
                mdl_st = 0; mdl_sf = 0; mdl_new = 4'h0;
                case (mode[i])
                    0: if (mdl_loss == 0) begin mode[i] = 1; rel_t[i] = 0; end
                       else if (wcnt[i] == TCYC - 1) begin mode[i] = 3; mdl_st = 1; end
                       else wcnt[i]++;
                    1, 2: if (mdl_loss != 0) begin mode[i] = 4; mdl_sf = 1; mdl_new = mdl_loss; end
                          else if (mode[i] == 1) begin
                              rel_t[i]++;
                              if (rel_t[i] == NR * GAP) mode[i] = 2;
                          end
                    3: if (mdl_loss == 0) begin mode[i] = 1; rel_t[i] = 0; end
                    default: if (retry[i] || clr[i]) begin mode[i] = 0; wcnt[i] = 0; end
                endcase
                m_tmo[i]  = mdl_st | (m_tmo[i] & !clr[i]);
                m_flt[i]  = mdl_sf | (m_flt[i] & !clr[i]);
                m_lost[i] = mdl_new | (clr[i] ? 4'h0 : m_lost[i]);
                for (int k = HIST - 1; k > 0; k--) hist[i][k] = hist[i][k-1];
                hist[i][0] = flags[i];
            end
        end
    end

    function automatic logic [2:0] mdl_rst(input int i);
        logic [2:0] r = '0;
        if (mode[i] == 2) r = '1;
        else if (mode[i] == 1)
            for (int k = 0; k < NR; k++) if (rel_t[i] >= (k + 1) * GAP) r[k] = 1'b1;
        return r;
    endfunction

    // {RST_N_OUT, ALL_DONE, TIMEOUT, FAULT, LOST_FLAGS, STATE}
    function automatic logic [12:0] exp_vec(input int i);
        return {mdl_rst(i), mode[i] == 2, m_tmo[i], m_flt[i], m_lost[i], 3'(mode[i])};
    endfunction

    function automatic logic [12:0] obs(input int i);
        case (i)
            0: return {ifa.RST_N_OUT, ifa.ALL_DONE, ifa.TIMEOUT, ifa.FAULT, ifa.LOST_FLAGS, ifa.STATE};
            1: return {ifb.RST_N_OUT, ifb.ALL_DONE, ifb.TIMEOUT, ifb.FAULT, ifb.LOST_FLAGS, ifb.STATE};
            default: return {ifc.RST_N_OUT, ifc.ALL_DONE, ifc.TIMEOUT, ifc.FAULT, ifc.LOST_FLAGS, ifc.STATE};
        endcase
    endfunction

    task automatic local_reset(input int i);
        rstn[i] = 1'b0;
        flags[i] = 4'h0;
        clr[i] = 1'b0;
        repeat (2) @(negedge clk);
        rstn[i] = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin rstn[i] = 0; flags[i] = 4'hF; clr[i] = 0; end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (obs(i) !== 13'b0) begin
                n_fail++;
                $display("FAIL reset inst%0d: got %b expected %b", i, obs(i), 13'b0);
            end
        end
        for (int i = 0; i < 3; i++) begin rstn[i] = 1; flags[i] = 4'h0; end
    endtask

    task automatic test_release();
        int rel_at = -1;
        logic [2:0] er;
        flags[0] = 4'hF;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (obs(i) !== exp_vec(i)) begin
                    n_fail++;
                    $display("FAIL release inst%0d cyc%0d: got %b expected %b", i, c, obs(i), exp_vec(i));
                end
            end
            if (rel_at < 0 && ifa.STATE == 3'd1) rel_at = c;
            if (rel_at > 0 && (c == rel_at + 2 || c == rel_at + 4 || c == rel_at + 6)) begin
                er = (c == rel_at + 2) ? 3'b001 : (c == rel_at + 4) ? 3'b011 : 3'b111;
                n_checks++;
                if ({ifa.RST_N_OUT, ifa.ALL_DONE} !== {er, er == 3'b111}) begin
                    n_fail++;
                    $display("FAIL release_order +%0d: got %b expected %b", c - rel_at,
                             {ifa.RST_N_OUT, ifa.ALL_DONE}, {er, er == 3'b111});
                end
            end
        end
        // Stable after 6 edges, the FSM moves to RELEASE on the 7th.
        n_checks++;
        if (rel_at !== 7) begin
            n_fail++;
            $display("FAIL release_latency: got %0d expected %0d", rel_at, 7);
        end
    endtask

    task automatic test_glitch();
        local_reset(1);
        flags[1] = 4'b1011;
        for (int c = 1; c <= 23; c++) begin
            if (c == 9)  flags[1] = 4'b1111;
            if (c == 12) flags[1] = 4'b1011;
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (obs(i) !== exp_vec(i)) begin
                    n_fail++;
                    $display("FAIL glitch inst%0d cyc%0d: got %b expected %b", i, c, obs(i), exp_vec(i));
                end
            end
        end
        n_checks++;
        if (ifb.STATE !== 3'd0) begin
            n_fail++;
            $display("FAIL glitch_state: got %0d expected %0d", ifb.STATE, 0);
        end
    endtask

    task automatic test_timeout();
        local_reset(0);
        flags[0] = 4'h7;
        for (int c = 1; c <= 55; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (obs(i) !== exp_vec(i)) begin
                    n_fail++;
                    $display("FAIL timeout inst%0d cyc%0d: got %b expected %b", i, c, obs(i), exp_vec(i));
                end
            end
            if (c == 49 || c == 50) begin
                n_checks++;
                if ({ifa.STATE, ifa.TIMEOUT} !== ((c == 49) ? 4'b0000 : 4'b0111)) begin
                    n_fail++;
                    $display("FAIL timeout_edge cyc%0d: got %b expected %b", c, {ifa.STATE, ifa.TIMEOUT},
                             (c == 49) ? 4'b0000 : 4'b0111);
                end
            end
        end
        flags[0] = 4'hF;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (obs(i) !== exp_vec(i)) begin
                    n_fail++;
                    $display("FAIL tmo_release inst%0d cyc%0d: got %b expected %b", i, c, obs(i), exp_vec(i));
                end
            end
        end
        n_checks++;
        if ({ifa.STATE, ifa.TIMEOUT, ifa.RST_N_OUT} !== {3'd2, 1'b1, 3'b111}) begin
            n_fail++;
            $display("FAIL tmo_sticky: got %b expected %b", {ifa.STATE, ifa.TIMEOUT, ifa.RST_N_OUT},
                     {3'd2, 1'b1, 3'b111});
        end
    endtask

    task automatic test_loss();
        flags[0] = 4'b1101;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (obs(i) !== exp_vec(i)) begin
                    n_fail++;
                    $display("FAIL loss inst%0d cyc%0d: got %b expected %b", i, c, obs(i), exp_vec(i));
                end
            end
            if (c == 4) begin
                n_checks++;
                if ({ifa.RST_N_OUT, ifa.ALL_DONE, ifa.FAULT, ifa.LOST_FLAGS, ifa.STATE} !==
                    {3'b000, 1'b0, 1'b1, 4'b0010, 3'd4}) begin
                    n_fail++;
                    $display("FAIL loss_fault: got %b expected %b",
                             {ifa.RST_N_OUT, ifa.ALL_DONE, ifa.FAULT, ifa.LOST_FLAGS, ifa.STATE},
                             {3'b000, 1'b0, 1'b1, 4'b0010, 3'd4});
                end
            end
            if (c == 5) begin
                n_checks++;
                if ({ifa.STATE, ifa.FAULT} !== {3'd0, 1'b1}) begin
                    n_fail++;
                    $display("FAIL loss_retry: got %b expected %b", {ifa.STATE, ifa.FAULT}, {3'd0, 1'b1});
                end
            end
        end
        flags[0] = 4'hF;
    endtask

    task automatic test_no_retry();
        local_reset(1);
        flags[1] = 4'hF;
        for (int c = 1; c <= 36; c++) begin
            if (c == 21) flags[1] = 4'b1101;
            if (c == 31) begin flags[1] = 4'hF; clr[1] = 1'b1; end
            if (c == 32) clr[1] = 1'b0;
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (obs(i) !== exp_vec(i)) begin
                    n_fail++;
                    $display("FAIL no_retry inst%0d cyc%0d: got %b expected %b", i, c, obs(i), exp_vec(i));
                end
            end
            if (c == 30) begin
                n_checks++;
                if ({ifb.STATE, ifb.FAULT, ifb.LOST_FLAGS, ifb.RST_N_OUT} !== {3'd4, 1'b1, 4'b0010, 3'b000}) begin
                    n_fail++;
                    $display("FAIL no_retry_hold: got %b expected %b",
                             {ifb.STATE, ifb.FAULT, ifb.LOST_FLAGS, ifb.RST_N_OUT}, {3'd4, 1'b1, 4'b0010, 3'b000});
                end
            end
            if (c == 31) begin
                n_checks++;
                if ({ifb.STATE, ifb.FAULT, ifb.LOST_FLAGS} !== {3'd0, 1'b0, 4'b0000}) begin
                    n_fail++;
                    $display("FAIL no_retry_clear: got %b expected %b",
                             {ifb.STATE, ifb.FAULT, ifb.LOST_FLAGS}, {3'd0, 1'b0, 4'b0000});
                end
            end
        end
    endtask

    task automatic test_reset_mid_release();
        bit found = 0;
        local_reset(2);
        flags[2] = 4'h7;
        for (int c = 1; c <= 30 && !found; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (obs(i) !== exp_vec(i)) begin
                    n_fail++;
                    $display("FAIL midrst inst%0d cyc%0d: got %b expected %b", i, c, obs(i), exp_vec(i));
                end
            end
            if (ifc.RST_N_OUT == 3'b011) found = 1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL midrst_reach: got RST_N_OUT %b expected %b", ifc.RST_N_OUT, 3'b011);
        end
        rstn[2] = 1'b0;
        #1;
        n_checks++;
        if (obs(2) !== 13'b0) begin
            n_fail++;
            $display("FAIL midrst_async: got %b expected %b", obs(2), 13'b0);
        end
        @(negedge clk);
        @(negedge clk);
        rstn[2] = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            if (c > 20) flags[2] = {1'($urandom_range(0, 1)), 3'b111};
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (obs(i) !== exp_vec(i)) begin
                    n_fail++;
                    $display("FAIL mask inst%0d cyc%0d: got %b expected %b", i, c, obs(i), exp_vec(i));
                end
            end
        end
        n_checks++;
        if ({ifc.STATE, ifc.FAULT, ifc.LOST_FLAGS} !== {3'd2, 1'b0, 4'b0000}) begin
            n_fail++;
            $display("FAIL mask_ignore: got %b expected %b", {ifc.STATE, ifc.FAULT, ifc.LOST_FLAGS},
                     {3'd2, 1'b0, 4'b0000});
        end
    endtask

    task automatic test_random();
        for (int c = 1; c <= 600; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (obs(i) !== exp_vec(i)) begin
                    n_fail++;
                    $display("FAIL random inst%0d cyc%0d: got %b expected %b", i, c, obs(i), exp_vec(i));
                end
            end
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 15) == 0) flags[i] ^= 4'(1 << $urandom_range(0, 3));
                if ($urandom_range(0, 23) == 0) flags[i] = 4'hF;
                clr[i]  = ($urandom_range(0, 29) == 0);
                rstn[i] = ($urandom_range(0, 299) != 0);
            end
        end
        for (int i = 0; i < 3; i++) begin clr[i] = 0; rstn[i] = 1; end
    endtask

    initial begin
        test_reset();
        test_release();
        test_glitch();
        test_timeout();
        test_loss();
        test_no_retry();
        test_reset_mid_release();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d failures %0d", n_checks, n_fail);
        $fatal(1);
    end

endmodule
